outport_uart_tx: RTL
====================

// Module: outport_uart_tx
// PURPOSE
//  Downstream consumer of the CPU output port. Each CPU outport write strobe
//  pushes the low byte of the written word into a small FIFO. The bytes are
//  then sent as 8N1 UART frames on a single tx line.
//  Sits between cpu.outport and the board pin, so program output is visible
//  on a serial terminal and can be checked by the bench.
// PARAMETERS
//  n             32   CPU data width; width of wr_data
//  CLKS_PER_BIT  10   clock cycles per serial bit (>=2)
//  DEPTH         4    FIFO depth in bytes (power of 2, >=2)
// PORTS
//  clock    in   1   system clock; all state changes on its rising edge
//  reset    in   1   asynchronous, active-low reset (0 = in reset)
//  wr_data  in   n   CPU outport value; only bits [7:0] are used
//  wr_en    in   1   outport write strobe; one byte pushed per high cycle
//  full     out  1   FIFO holds DEPTH bytes; further writes are rejected
//  dropped  out  1   sticky: at least one write was rejected since reset
//  busy     out  1   FIFO not empty or frame in progress
//  tx       out  1   serial line, idle high, registered output
// BEHAVIOUR
//  Reset (reset=0, async): tx=1, full=0, dropped=0, busy=0.
//   Also state=IDLE, FIFO pointers and count=0, bit/clock counters=0.
//   Reset during a frame aborts it at once (tx=1). FIFO contents are lost.
//  Push: wr_en=1 & full=0 at an edge -> wr_data[7:0] written at tail; count+1.
//   wr_en=1 & full=1 -> write ignored; dropped<=1; stays 1 until reset.
//   full is decoded from the current count, so a push while full is rejected
//   even if a pop happens in the same cycle.
//  Pop: only in IDLE with count!=0. Head byte is loaded into the shift
//   register; state moves to START on that edge.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//  Pointers wrap modulo DEPTH. count ranges 0..DEPTH (width log2(DEPTH)+1).
//  FSM, one bit time = CLKS_PER_BIT cycles:
//   IDLE : tx=1. If count!=0, pop and go to START, else stay in IDLE.
//   START: tx=0 for one bit time, then go to DATA with bit index 0.
//   DATA : tx=shift[0] for one bit time, then shift right. After 8 bits
//          (LSB first), go to STOP.
//   STOP : tx=1 for one bit time, then go to IDLE.
//  Latency: write accepted at edge k (FIFO empty, IDLE) -> pop at edge k+1.
//   tx falls after edge k+1. Frame = 10*CLKS_PER_BIT cycles.
//  Back-to-back frames: exactly 1 IDLE cycle (tx=1) between the end of STOP
//   and the next START.
//  busy = (state!=IDLE) | (count!=0), registered-consistent with state/count.
//  Every output, including tx, comes straight from a flop. No combinational
//   path from wr_en to tx.
// TESTING (CLKS_PER_BIT=10, DEPTH=4)
//  1 Hold reset=0 for 3 clocks, toggle wr_en
//    -> tx=1, full=0, busy=0, dropped=0 throughout.
//  2 One write of 0x00000055
//    -> tx=0 for 10 cycles, then bits 1,0,1,0,1,0,1,0 (10 cycles each),
//       then 1 for 10 cycles; busy=0 the cycle after STOP ends.
//  3 Write 0xDEADBEA5 -> decoded byte is 0xA5; upper 24 bits have no effect.
//  4 Six back-to-back writes 0x01..0x06
//    -> full=1 after the 5th; 0x06 is rejected and dropped=1.
//       Serial bytes are 01,02,03,04,05 with 1-cycle gaps.
//  5 Assert reset=0 mid-frame, during data bit 3
//    -> tx=1 and busy=0 immediately, with no clock edge.
//       After release, tx stays 1 and no residual frame is sent.
//  6 Write during the STOP bit of a frame -> next START follows STOP
//    after exactly 1 idle cycle; count returns to 0; busy stays 1 until done.

Source files
------------

// File: rtl/outport_uart_tx.sv
// -----------------------------------------------------------------------------
// outport_uart_tx
//
// Purpose:
//   Serialises CPU output-port writes onto a UART line. Each write strobe
//   pushes the low byte of the written word into a small FIFO. Bytes are
//   drained one at a time and sent as 8N1 frames (start bit, 8 data bits
//   LSB first, one stop bit), each bit lasting CLKS_PER_BIT clock cycles.
//
// Parameters:
//   n            - CPU data width (width of wr_data)
//   CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//   DEPTH        - FIFO depth in bytes (power of 2, >= 2)
//
// Ports:
//   clock    in   system clock, all state changes on the rising edge
//   reset    in   asynchronous active-low reset (0 = in reset)
//   wr_data  in   CPU outport value, only bits [7:0] are used
//   wr_en    in   outport write strobe, one byte pushed per high cycle
//   full     out  FIFO holds DEPTH bytes, further writes are rejected
//   dropped  out  sticky flag, a write was rejected since reset
//   busy     out  FIFO not empty or a frame is in progress
//   tx       out  serial line, idle high
//
// Every output is driven directly by a flop; the next-state values are
// computed from the next FSM state and FIFO count so the registered outputs
// stay cycle-consistent with the internal state.
// -----------------------------------------------------------------------------
module outport_uart_tx #(
    parameter int n            = 32,
    parameter int CLKS_PER_BIT = 10,
    parameter int DEPTH        = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [n-1:0] wr_data,
    input  logic         wr_en,
    output logic         full,
    output logic         dropped,
    output logic         busy,
    output logic         tx
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CLK_W-1:0] CLK_ZERO = {CLK_W{1'b0}};
    localparam logic [CLK_W-1:0] CLK_ONE  = CLK_W'(1);
    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // FIFO storage and pointers
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Transmitter state
    logic [1:0]       state_q, state_d;
    logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;

    // Registered outputs
    logic tx_q, tx_d;
    logic full_q, full_d;
    logic busy_q, busy_d;
    logic dropped_q, dropped_d;

    logic push_s;
    logic pop_s;
    logic bit_end_s;

    // full_q always equals (count_q == DEPTH), so a push while full is
    // rejected even when a pop happens on the same edge.
    assign push_s    = wr_en & ~full_q;
    assign pop_s     = (state_q == ST_IDLE) & (count_q != CNT_ZERO);
    assign bit_end_s = (clk_cnt_q == CLK_LAST);

    // FIFO pointer and occupancy next-state
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_ONE;
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Transmitter FSM next-state: bit timing, bit index and shift register
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = CLK_ZERO;
                bit_idx_d = 3'd0;
                if (pop_s) begin
                    shift_d = mem_q[rptr_q];
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    clk_cnt_d = CLK_ZERO;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    clk_cnt_d = CLK_ZERO;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    clk_cnt_d = CLK_ZERO;
                    state_d   = ST_IDLE;
                end else begin
                    clk_cnt_d = clk_cnt_q + CLK_ONE;
                end
            end
            default: begin
                clk_cnt_d = CLK_ZERO;
                bit_idx_d = 3'd0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Output next-state, derived from next state so the flops track the FSM
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
        full_d    = (count_d == CNT_FULL);
        busy_d    = (state_d != ST_IDLE) | (count_d != CNT_ZERO);
        dropped_d = dropped_q | (wr_en & full_q);
    end

    // FIFO byte storage; only the low byte of the CPU word is kept
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                mem_q[wptr_q] <= wr_data[7:0];
            end
        end
    end

    // State, counter and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q    <= PTR_ZERO;
            rptr_q    <= PTR_ZERO;
            count_q   <= CNT_ZERO;
            state_q   <= ST_IDLE;
            clk_cnt_q <= CLK_ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            full_q    <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            full_q    <= full_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign tx      = tx_q;
    assign full    = full_q;
    assign busy    = busy_q;
    assign dropped = dropped_q;

endmodule
